// File: rtl/board_io_pkg.sv
// Shared constants and types for the board_io_pio key/LED peripheral.
package board_io_pkg;

    localparam int BLINK_W = 24;

    typedef logic [2:0] reg_addr_t;

    localparam reg_addr_t ADDR_KEY_STATE    = 3'd0;
    localparam reg_addr_t ADDR_EDGE_CAPTURE = 3'd1;
    localparam reg_addr_t ADDR_IRQ_MASK     = 3'd2;
    localparam reg_addr_t ADDR_LED_OUT      = 3'd3;
    localparam reg_addr_t ADDR_LED_BLINK    = 3'd4;
    localparam reg_addr_t ADDR_BLINK_HALF   = 3'd5;

endpackage

// File: rtl/board_io_pio_key_debounce.sv
// Per-key synchroniser and debouncer; pressed_pulse_o marks the cycle the
// debounced state is about to go from released to pressed.
module key_debounce
    import board_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n_i,
    output logic state_o,
    output logic pressed_pulse_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             pressed_s;
    logic             expire_s;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             state_q, state_d;

    // Sync flops idle at the released level so a held key is seen as a fresh press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            state_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], key_n_i};
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign pressed_s = ~sync_q[1];
    assign expire_s  = (pressed_s != state_q) && (cnt_q == CNT_LAST);

    // Count consecutive disagreeing cycles; accept the new level when the count expires.
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        if (pressed_s == state_q) begin
            cnt_d = '0;
        end else if (expire_s) begin
            cnt_d   = '0;
            state_d = pressed_s;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign state_o         = state_q;
    assign pressed_pulse_o = expire_s & pressed_s;

endmodule

// File: rtl/board_io_pio.sv
// Avalon-MM key/LED PIO: debounced keys, edge capture with maskable irq, LED bank.
// Define BOARD_IO_PIO_BLINK_EN to build the blink engine (LED_BLINK, BLINK_HALF).
module board_io_pio
    import board_io_pkg::*;
#(
    parameter int NUM_KEYS        = 3,
    parameter int NUM_LEDS        = 26,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  reg_addr_t           address,
    input  logic                read,
    input  logic                write,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic                irq,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_LEDS-1:0] leds
);

    logic [NUM_KEYS-1:0] key_state_s, press_s;
    logic [NUM_KEYS-1:0] edge_q, edge_d, mask_q, mask_d, w1c_s;
    logic [NUM_LEDS-1:0] led_out_q, led_out_d, led_mask_s, leds_q, leds_d;
    logic [31:0]         rd_mux_s, readdata_q, readdata_d;
    logic                irq_q, irq_d;
    logic                unused_s;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key (
            .clk            (clk),
            .reset_n        (reset_n),
            .key_n_i        (key_n[k]),
            .state_o        (key_state_s[k]),
            .pressed_pulse_o(press_s[k])
        );
    end

    assign unused_s = ^writedata;

`ifdef BOARD_IO_PIO_BLINK_EN
    logic [NUM_LEDS-1:0] blink_q, blink_d;
    logic [BLINK_W-1:0]  half_q, half_d, bcnt_q, bcnt_d;
    logic                phase_q, phase_d;
    logic                wr_half_s;

    assign wr_half_s = write && (address == ADDR_BLINK_HALF);

    // Blink register writes and the half-period counter that drives phase.
    always_comb begin
        blink_d = blink_q;
        half_d  = half_q;
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (write && (address == ADDR_LED_BLINK)) begin
            blink_d = writedata[NUM_LEDS-1:0];
        end else begin
            blink_d = blink_q;
        end
        if (wr_half_s) begin
            half_d  = writedata[BLINK_W-1:0];
            bcnt_d  = '0;
            phase_d = 1'b1;
        end else if (half_q == '0) begin
            bcnt_d  = '0;
            phase_d = 1'b1;
        end else if (bcnt_q == half_q - BLINK_W'(1)) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end else begin
            bcnt_d = bcnt_q + BLINK_W'(1);
        end
    end

    // Blink state registers; phase idles high so blinking LEDs start lit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_q <= '0;
            half_q  <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b1;
        end else begin
            blink_q <= blink_d;
            half_q  <= half_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end

    assign led_mask_s = ~blink_q | {NUM_LEDS{phase_q}};
`else
    assign led_mask_s = '1;
`endif

    // Register file next state; a capture event overrides a same-cycle W1C.
    always_comb begin
        w1c_s     = '0;
        mask_d    = mask_q;
        led_out_d = led_out_q;
        if (write && (address == ADDR_EDGE_CAPTURE)) begin
            w1c_s = writedata[NUM_KEYS-1:0];
        end else begin
            w1c_s = '0;
        end
        if (write && (address == ADDR_IRQ_MASK)) begin
            mask_d = writedata[NUM_KEYS-1:0];
        end else begin
            mask_d = mask_q;
        end
        if (write && (address == ADDR_LED_OUT)) begin
            led_out_d = writedata[NUM_LEDS-1:0];
        end else begin
            led_out_d = led_out_q;
        end
        edge_d = (edge_q & ~w1c_s) | press_s;
        irq_d  = |(edge_q & mask_q);
        leds_d = led_out_q & led_mask_s;
    end

    // Read mux sees pre-write register values.
    always_comb begin
        rd_mux_s = 32'h0;
        case (address)
            ADDR_KEY_STATE:    rd_mux_s = 32'(key_state_s);
            ADDR_EDGE_CAPTURE: rd_mux_s = 32'(edge_q);
            ADDR_IRQ_MASK:     rd_mux_s = 32'(mask_q);
            ADDR_LED_OUT:      rd_mux_s = 32'(led_out_q);
`ifdef BOARD_IO_PIO_BLINK_EN
            ADDR_LED_BLINK:    rd_mux_s = 32'(blink_q);
            ADDR_BLINK_HALF:   rd_mux_s = 32'(half_q);
`endif
            default:           rd_mux_s = 32'h0;
        endcase
        readdata_d = read ? rd_mux_s : 32'h0;
    end

    // Register file and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_q     <= '0;
            mask_q     <= '0;
            led_out_q  <= '0;
            leds_q     <= '0;
            readdata_q <= 32'h0;
            irq_q      <= 1'b0;
        end else begin
            edge_q     <= edge_d;
            mask_q     <= mask_d;
            led_out_q  <= led_out_d;
            leds_q     <= leds_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;
    assign leds     = leds_q;

endmodule

// File: tb/tb_board_io_pio.sv
// Directed bench for board_io_pio (DEBOUNCE_CYCLES=16) with a cycle model and literal checks.
module tb_board_io_pio;

    localparam int D  = 16;
    localparam int NK = 3;
    localparam int NL = 26;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [2:0]    address = 3'd0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [31:0]   writedata = 32'h0;
    logic [31:0]   readdata;
    logic          irq;
    logic [NK-1:0] key_n = 3'b111;
    logic [NL-1:0] leds;

    int total = 0;
    int bad = 0;
    logic chk_on = 1'b0;

    board_io_pio #(
        .NUM_KEYS(NK), .NUM_LEDS(NL), .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
        .writedata(writedata), .readdata(readdata), .irq(irq), .key_n(key_n), .leds(leds)
    );

    always #5 clk = ~clk;

    // Reference model: each key's debounced level follows the 2-cycle-delayed
    // raw level once it has disagreed for D consecutive cycles.
    logic [NK-1:0] m_state, m_edge, m_mask, m_h1, m_h2, set_v, w1c_v;
    logic [NL-1:0] m_led, m_blink, m_leds;
    logic [23:0]   m_half;
    logic [31:0]   m_rd;
    logic          m_irq, m_rd_valid, m_phase;
    int            m_run [NK];
    int            m_elapsed;

    function automatic logic [31:0] regmap(input logic [2:0] a);
        case (a)
            3'd0: return 32'(m_state);
            3'd1: return 32'(m_edge);
            3'd2: return 32'(m_mask);
            3'd3: return 32'(m_led);
`ifdef BOARD_IO_PIO_BLINK_EN
            3'd4: return 32'(m_blink);
            3'd5: return 32'(m_half);
`endif
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_state = '0; m_edge = '0; m_mask = '0; m_h1 = '0; m_h2 = '0;
            m_led = '0; m_blink = '0; m_leds = '0; m_half = '0;
            m_rd = '0; m_irq = 1'b0; m_rd_valid = 1'b0; m_phase = 1'b1; m_elapsed = 0;
            for (int k = 0; k < NK; k++) m_run[k] = 0;
        end else begin
            m_rd_valid = read;
            if (read) m_rd = regmap(address);
            m_irq  = |(m_edge & m_mask);
            m_leds = m_led & (~m_blink | {NL{m_phase}});
            set_v = '0;
            for (int k = 0; k < NK; k++) begin
                if (m_h2[k] != m_state[k]) begin
                    m_run[k]++;
                    if (m_run[k] == D) begin
                        m_state[k] = m_h2[k];
                        m_run[k] = 0;
                        set_v[k] = m_h2[k];
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
            m_h2 = m_h1;
            m_h1 = ~key_n;
            w1c_v = (write && address == 3'd1) ? writedata[NK-1:0] : '0;
            m_edge = (m_edge & ~w1c_v) | set_v;
            if (write && address == 3'd2) m_mask = writedata[NK-1:0];
            if (write && address == 3'd3) m_led = writedata[NL-1:0];
            m_elapsed++;
`ifdef BOARD_IO_PIO_BLINK_EN
            if (write && address == 3'd4) m_blink = writedata[NL-1:0];
            if (write && address == 3'd5) begin
                m_half = writedata[23:0];
                m_elapsed = 0;
            end
`endif
            m_phase = (m_half == 24'd0) ? 1'b1 : (((m_elapsed / int'(m_half)) % 2) == 0);
        end
    end

    // Cycle-by-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (chk_on) begin
            total++;
            if (irq !== m_irq) begin
                bad++;
                $display("FAIL irq_cyc t=%0t got=%b exp=%b", $time, irq, m_irq);
            end
            total++;
            if (leds !== m_leds) begin
                bad++;
                $display("FAIL leds_cyc t=%0t got=%h exp=%h", $time, leds, m_leds);
            end
            if (m_rd_valid) begin
                total++;
                if (readdata !== m_rd) begin
                    bad++;
                    $display("FAIL readdata_cyc t=%0t got=%h exp=%h", $time, readdata, m_rd);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        cyc();
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address = a; read = 1'b1;
        cyc();
        read = 1'b0;
        d = readdata;
    endtask

    logic [31:0] rd;
    int          got, toggles;
    logic        prev, steady;

    initial begin
        #1 reset_n = 1'b0;
        #1 chk_on = 1'b1;
        repeat (3) cyc();
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_leds", 32'(leds), 32'h0);
        chk("rst_readdata", readdata, 32'h0);
        reset_n = 1'b1;
        bus_read(3'd5, rd); chk("rd_addr5_reset", rd, 32'h0);

        // 8-cycle glitch is too short to register
        key_n[1] = 1'b0; repeat (8) cyc(); key_n[1] = 1'b1;
        repeat (30) cyc();
        bus_read(3'd0, rd); chk("glitch_state", rd, 32'h0);
        bus_read(3'd1, rd); chk("glitch_edge", rd, 32'h0);

        // bounce then stable press of key 1
        bus_write(3'd2, 32'h2);
        for (int i = 0; i < 5; i++) begin key_n[1] = ~key_n[1]; cyc(); end
        repeat (20) cyc();
        bus_read(3'd0, rd); chk("press_state", rd, 32'h2);
        bus_read(3'd1, rd); chk("press_edge", rd, 32'h2);
        chk("press_irq", 32'(irq), 32'h1);

        // read and write of the same register in one cycle
        address = 3'd2; writedata = 32'h3; write = 1'b1; read = 1'b1;
        cyc();
        write = 1'b0; read = 1'b0;
        chk("rw_same_cycle", readdata, 32'h2);
        bus_read(3'd2, rd); chk("rw_after", rd, 32'h3);
        bus_write(3'd2, 32'h2);

        // keys 0 and 2 pressed then released: no edge on release
        key_n = 3'b000; repeat (20) cyc();
        bus_read(3'd0, rd); chk("multi_state", rd, 32'h7);
        bus_read(3'd1, rd); chk("multi_edge", rd, 32'h7);
        key_n = 3'b101; repeat (20) cyc();
        bus_read(3'd0, rd); chk("release_state", rd, 32'h2);
        bus_read(3'd1, rd); chk("release_edge", rd, 32'h7);
        bus_write(3'd1, 32'h5);
        bus_read(3'd1, rd); chk("w1c_partial", rd, 32'h2);

        // W1C lands in the cycle a new key-1 press is captured
        key_n = 3'b111; repeat (20) cyc();
        key_n[1] = 1'b0;
        repeat (D + 1) cyc();
        bus_write(3'd1, 32'h2);
        chk("collide_irq", 32'(irq), 32'h1);
        bus_read(3'd1, rd); chk("collide_edge", rd, 32'h2);
        bus_write(3'd1, 32'h2);
        chk("irq_hold_w1c", 32'(irq), 32'h1);
        cyc();
        chk("irq_fall", 32'(irq), 32'h0);

        // LED output register
        bus_write(3'd3, 32'hFFFF_FFFF);
        cyc(); chk("leds_all", 32'(leds), 32'h03FF_FFFF);
        bus_read(3'd3, rd); chk("led_out_rd", rd, 32'h03FF_FFFF);
        bus_write(3'd3, 32'h0155_AA55);
        cyc(); chk("leds_pattern", 32'(leds), 32'h0155_AA55);
`ifdef BOARD_IO_PIO_BLINK_EN
        bus_write(3'd3, 32'h03FF_FFFF);
        bus_write(3'd4, 32'h1);
        bus_write(3'd5, 32'h4);
        bus_read(3'd5, rd); chk("half_rd", rd, 32'h4);
        prev = leds[0]; toggles = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (leds[0] != prev) toggles++;
            prev = leds[0];
        end
        chk("blink_toggles", 32'(toggles), 32'd4);
        chk("blink_others", 32'(leds[25:1]), 32'h01FF_FFFF);
        bus_write(3'd5, 32'h0);
        steady = 1'b1;
        for (int i = 0; i < 12; i++) begin cyc(); if (leds[0] !== 1'b1) steady = 1'b0; end
        chk("blink_half0", 32'(steady), 32'h1);
`else
        bus_write(3'd4, 32'hFF);
        bus_read(3'd4, rd); chk("no_blink_rd4", rd, 32'h0);
        bus_write(3'd5, 32'h4);
        bus_read(3'd5, rd); chk("no_blink_rd5", rd, 32'h0);
        chk("no_blink_leds", 32'(leds), 32'h0155_AA55);
`endif
        bus_write(3'd6, 32'hFFFF_FFFF);
        bus_read(3'd6, rd); chk("rd_addr6", rd, 32'h0);
        bus_read(3'd7, rd); chk("rd_addr7", rd, 32'h0);

        // reset mid-debounce with key 1 still held
        key_n = 3'b111; repeat (20) cyc();
        bus_write(3'd1, 32'h7);
        key_n[1] = 1'b0;
        repeat (12) cyc();
        reset_n = 1'b0;
        cyc(); cyc();
        reset_n = 1'b1;
        bus_write(3'd2, 32'h2);
        bus_read(3'd0, rd); chk("rst_mid_state", rd, 32'h0);
        got = 0;
        for (int n = 3; n <= 40; n++) begin
            cyc();
            if (irq && got == 0) got = n;
        end
        chk("held_irq_cycle", 32'(got), 32'(D + 3));
        bus_read(3'd0, rd); chk("held_state", rd, 32'h2);
        bus_read(3'd1, rd); chk("held_edge", rd, 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
